// File: rtl/sr_pkg.sv
// Shared definitions for the set/reset register bank: S=R=1 resolution modes
// and the single-channel next-state rule.
package sr_pkg;

  localparam logic [1:0] SR_MODE_RDOM = 2'd0;
  localparam logic [1:0] SR_MODE_SDOM = 2'd1;
  localparam logic [1:0] SR_MODE_HOLD = 2'd2;
  localparam logic [1:0] SR_MODE_TOG  = 2'd3;

  // Next state of one enabled channel; the mode only matters when s=r=1.
  function automatic logic sr_next(input logic [1:0] mode, input logic q,
                                   input logic s, input logic r);
    logic nq;
    case ({s, r})
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      2'b11: begin
        case (mode)
          SR_MODE_RDOM: nq = 1'b0;
          SR_MODE_SDOM: nq = 1'b1;
          SR_MODE_HOLD: nq = q;
          SR_MODE_TOG:  nq = ~q;
          default:      nq = 1'b0;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One set/reset channel: the q flop with its edge-pulse and conflict flops.
module sr_cell
  import sr_pkg::*;
#(
  parameter int MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic s,
  input  logic r,
  output logic q,
  output logic rise,
  output logic fall,
  output logic conflict,
  output logic conflict_next
);

  localparam logic [1:0] MODE_SEL = MODE[1:0];

  logic q_r;
  logic rise_r;
  logic fall_r;
  logic conflict_r;
  logic q_next_s;

  // Next-state selection: clr overrides everything, en gates s/r.
  always_comb begin
    q_next_s = q_r;
    if (clr) begin
      q_next_s = 1'b0;
    end else if (en) begin
      q_next_s = sr_next(MODE_SEL, q_r, s, r);
    end else begin
      q_next_s = q_r;
    end
  end

  // Conflict is judged on the raw request, independent of clr and mode.
  assign conflict_next = en & s & r;

  // State and pulse registers; pulses compare the old and new q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r        <= 1'b0;
      rise_r     <= 1'b0;
      fall_r     <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      q_r        <= q_next_s;
      rise_r     <= ~q_r & q_next_s;
      fall_r     <= q_r & ~q_next_s;
      conflict_r <= conflict_next;
    end
  end

  assign q        = q_r;
  assign rise     = rise_r;
  assign fall     = fall_r;
  assign conflict = conflict_r;

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH clocked set/reset channels with conflict reporting, a
// saturating conflict counter and a sticky error flag.
module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             err_sticky,
  input  logic             err_clr
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_reg_bank: MODE must be 0..3");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] conflict_next_s;
  logic             conflict_any_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             err_r;
  logic             err_next_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(.MODE(MODE)) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .clr          (clr),
      .s            (s[i]),
      .r            (r[i]),
      .q            (q[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .conflict     (conflict[i]),
      .conflict_next(conflict_next_s[i])
    );
  end

  assign conflict_any_s = |conflict_next_s;

  // Counter and sticky flag: a fresh conflict wins over err_clr.
  always_comb begin
    cnt_next_s = cnt_r;
    err_next_s = err_r;
    if (err_clr) begin
      cnt_next_s = conflict_any_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (conflict_any_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
    if (conflict_any_s) begin
      err_next_s = 1'b1;
    end else if (err_clr) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = err_r;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      err_r <= err_next_s;
    end
  end

  assign qb           = ~q;
  assign conflict_cnt = cnt_r;
  assign err_sticky   = err_r;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Self-checking bench: four banks (MODE 0..3, the MODE 3 bank with a 2-bit
// counter) share stimulus and are compared against a vector-level model.
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] s = 8'h00;
  logic [7:0] r = 8'h00;

  logic [7:0] q_o    [4];
  logic [7:0] qb_o   [4];
  logic [7:0] rise_o [4];
  logic [7:0] fall_o [4];
  logic [7:0] conf_o [4];
  logic [7:0] cnt_o  [4];
  logic       err_o  [4];
  logic [1:0] cnt_small;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mq    [4];
  logic [7:0] mrise [4];
  logic [7:0] mfall [4];
  logic [7:0] mconf [4];
  int         mcnt  [4];
  logic       merr  [4];

  always #5 clk = ~clk;

  sr_reg_bank #(.WIDTH(8), .MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(q_o[0]), .qb(qb_o[0]), .rise(rise_o[0]), .fall(fall_o[0]),
    .conflict(conf_o[0]), .conflict_cnt(cnt_o[0]), .err_sticky(err_o[0]),
    .err_clr(err_clr));
  sr_reg_bank #(.WIDTH(8), .MODE(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(q_o[1]), .qb(qb_o[1]), .rise(rise_o[1]), .fall(fall_o[1]),
    .conflict(conf_o[1]), .conflict_cnt(cnt_o[1]), .err_sticky(err_o[1]),
    .err_clr(err_clr));
  sr_reg_bank #(.WIDTH(8), .MODE(2), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(q_o[2]), .qb(qb_o[2]), .rise(rise_o[2]), .fall(fall_o[2]),
    .conflict(conf_o[2]), .conflict_cnt(cnt_o[2]), .err_sticky(err_o[2]),
    .err_clr(err_clr));
  sr_reg_bank #(.WIDTH(8), .MODE(3), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
    .q(q_o[3]), .qb(qb_o[3]), .rise(rise_o[3]), .fall(fall_o[3]),
    .conflict(conf_o[3]), .conflict_cnt(cnt_small), .err_sticky(err_o[3]),
    .err_clr(err_clr));

  assign cnt_o[3] = {6'b000000, cnt_small};

  function automatic int cnt_max(input int k);
    return (k == 3) ? 3 : 255;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k] = 8'h00; mrise[k] = 8'h00; mfall[k] = 8'h00;
      mconf[k] = 8'h00; mcnt[k] = 0; merr[k] = 1'b0;
    end
  endtask

  // One clock edge: model consumes the current inputs, DUT is then sampled
  // at the falling edge by the caller.
  task automatic cycle();
    logic [7:0] both, set_only, rst_only, both_val, nq;
    logic       any;
    @(posedge clk);
    both = s & r; set_only = s & ~r; rst_only = r & ~s;
    any = en && (both != 8'h00);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: both_val = 8'h00;
        1: both_val = both;
        2: both_val = mq[k] & both;
        default: both_val = ~mq[k] & both;
      endcase
      if (clr) nq = 8'h00;
      else if (en) nq = (mq[k] & ~(s | r)) | set_only | both_val;
      else nq = mq[k];
      mrise[k] = ~mq[k] & nq;
      mfall[k] = mq[k] & ~nq;
      mconf[k] = en ? both : 8'h00;
      mq[k] = nq;
      if (err_clr) mcnt[k] = any ? 1 : 0;
      else if (any && mcnt[k] < cnt_max(k)) mcnt[k] = mcnt[k] + 1;
      if (any) merr[k] = 1'b1;
      else if (err_clr) merr[k] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic c, input logic ec,
                       input logic [7:0] sv, input logic [7:0] rv);
    en = e; clr = c; err_clr = ec; s = sv; r = rv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_o[k] !== 8'h00 || qb_o[k] !== 8'hFF || rise_o[k] !== 8'h00 ||
          fall_o[k] !== 8'h00 || conf_o[k] !== 8'h00 || cnt_o[k] !== 8'h00 ||
          err_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: q=%h qb=%h rise=%h fall=%h conf=%h cnt=%h err=%b, need 00 ff 00 00 00 00 0",
                 k, q_o[k], qb_o[k], rise_o[k], fall_o[k], conf_o[k], cnt_o[k], err_o[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_set_basic();
    drive(1'b1, 1'b0, 1'b0, 8'h0F, 8'h00);
    cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_o[k] !== 8'h0F || qb_o[k] !== 8'hF0 || rise_o[k] !== 8'h0F) begin
        errors++;
        $display("FAIL set_basic inst%0d: q=%h qb=%h rise=%h, need 0f f0 0f",
                 k, q_o[k], qb_o[k], rise_o[k]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rise_o[k] !== 8'h00 || q_o[k] !== 8'h0F) begin
        errors++;
        $display("FAIL rise_pulse inst%0d: rise=%h q=%h, need 00 0f", k, rise_o[k], q_o[k]);
      end
    end
  endtask

  task automatic test_modes();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h00; exp_q[1] = 8'hFF; exp_q[2] = 8'hAA; exp_q[3] = 8'h55;
    drive(1'b1, 1'b0, 1'b1, 8'hAA, 8'h55);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_o[k] !== exp_q[k] || conf_o[k] !== 8'hFF || cnt_o[k] !== 8'd1 ||
          err_o[k] !== 1'b1) begin
        errors++;
        $display("FAIL mode_resolve inst%0d: q=%h conf=%h cnt=%0d err=%b, need %h ff 1 1",
                 k, q_o[k], conf_o[k], cnt_o[k], err_o[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_clr();
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_o[k] !== 8'h00 || fall_o[k] !== 8'hFF || conf_o[k] !== 8'h00) begin
        errors++;
        $display("FAIL clr inst%0d: q=%h fall=%h conf=%h, need 00 ff 00",
                 k, q_o[k], fall_o[k], conf_o[k]);
      end
    end
  endtask

  task automatic test_saturate();
    int exp3 [5] = '{1, 2, 3, 3, 3};
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    cycle();
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h01, 8'h01);
      cycle();
      checks++;
      if (cnt_o[3] !== exp3[n][7:0] || cnt_o[0] !== 8'(n + 1)) begin
        errors++;
        $display("FAIL saturate step%0d: cnt2bit=%0d cnt8bit=%0d, need %0d %0d",
                 n, cnt_o[3], cnt_o[0], exp3[n], n + 1);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt_o[k] !== 8'h00 || err_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL err_clr inst%0d: cnt=%0d err=%b, need 0 0", k, cnt_o[k], err_o[k]);
      end
    end
  endtask

  task automatic test_errclr_conflict();
    drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h10);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h10);
    cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt_o[k] !== 8'd1 || err_o[k] !== 1'b1) begin
        errors++;
        $display("FAIL errclr_conflict inst%0d: cnt=%0d err=%b, need 1 1", k, cnt_o[k], err_o[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h5A, 8'hA5);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_o[k] !== 8'h00 || qb_o[k] !== 8'hFF) begin
        errors++;
        $display("FAIL async_reset inst%0d: q=%h qb=%h, need 00 ff", k, q_o[k], qb_o[k]);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_en_low();
    drive(1'b1, 1'b0, 1'b0, 8'h3C, 8'hC3);
    cycle();
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (q_o[k] !== 8'h3C || conf_o[k] !== 8'h00) begin
          errors++;
          $display("FAIL en_low inst%0d: q=%h conf=%h, need 3c 00", k, q_o[k], conf_o[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 19) == 0), 8'($urandom), 8'($urandom));
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (q_o[k] !== mq[k] || qb_o[k] !== ~mq[k] || rise_o[k] !== mrise[k] ||
            fall_o[k] !== mfall[k] || conf_o[k] !== mconf[k] ||
            cnt_o[k] !== 8'(mcnt[k]) || err_o[k] !== merr[k]) begin
          errors++;
          $display("FAIL random n%0d inst%0d: q=%h rise=%h fall=%h conf=%h cnt=%0d err=%b, need %h %h %h %h %0d %b",
                   n, k, q_o[k], rise_o[k], fall_o[k], conf_o[k], cnt_o[k], err_o[k],
                   mq[k], mrise[k], mfall[k], mconf[k], mcnt[k], merr[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_set_basic();
    test_modes();
    test_clr();
    test_saturate();
    test_errclr_conflict();
    test_async_reset();
    test_en_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
